// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state encoding and request validity check for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Reduction flags are only meaningful for AND/XOR; elsewhere they make the request invalid.
  function automatic logic is_invalid(input logic [2:0] op, input logic red_a, input logic red_b);
    logic reserved_op;
    logic arith_op;
    reserved_op = (op == 3'b110) || (op == 3'b111);
    arith_op    = (op == OP_ADD) || (op == OP_MUL) || (op == OP_SHIFT) || (op == OP_ROT);
    return reserved_op || ((red_a || red_b) && arith_op);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier; the first partial product is folded into the load.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [DW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Load performs iteration 1; the remaining WIDTH-1 iterations run one per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = b[0] ? DW'(a) : '0;
      mcand_d  = DW'(a) << 1;
      mplier_d = b >> 1;
      cnt_d    = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      done_d   = (cnt_q == CW'(1));
    end
  end

  // Engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU: single-cycle ops, iterative multiply, saturating invalid counter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FULL_ADDER = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Out,
  output logic                 Odd_parity,
  output logic                 Invalid,
  output logic [CNT_W-1:0]     invalid_cnt
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + 1;
  localparam logic        FA_EN = (FULL_ADDER != 0);

  state_e           state_q, state_d;
  logic [DW-1:0]    out_q, out_d;
  logic             par_q, par_d;
  logic             inv_q, inv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_c;
  logic             req_inv_c;
  logic             req_mul_c;
  logic             mul_start_c;
  logic [SW-1:0]    sum_c;
  logic [DW-1:0]    res_c;
  logic             mul_busy, mul_done;
  logic [DW-1:0]    mul_product;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept_c  = in_valid && in_ready;

  // Request classification; only a genuine multiply is routed through the engine.
  assign req_inv_c = is_invalid(opcode, red_op_A, red_op_B);
  assign req_mul_c = (opcode == OP_MUL) && !req_inv_c && !bypass_A && !bypass_B;
  assign sum_c     = SW'(A) + SW'(B) + SW'(cin & FA_EN);

  // Single-cycle result with invalid > bypass_A > bypass_B > opcode priority.
  always_comb begin
    res_c = '0;
    if (req_inv_c) begin
      res_c = '0;
    end else if (bypass_A) begin
      res_c = DW'(A);
    end else if (bypass_B) begin
      res_c = DW'(B);
    end else begin
      case (opcode)
        OP_AND: begin
          if (red_op_A)      res_c = DW'(&A);
          else if (red_op_B) res_c = DW'(&B);
          else               res_c = DW'(A & B);
        end
        OP_XOR: begin
          if (red_op_A)      res_c = DW'(^A);
          else if (red_op_B) res_c = DW'(^B);
          else               res_c = DW'(A ^ B);
        end
        OP_ADD:   res_c = DW'(sum_c);
        OP_SHIFT: res_c = direction ? DW'({A[WIDTH-2:0], serial_in})
                                    : DW'({serial_in, A[WIDTH-1:1]});
        OP_ROT:   res_c = direction ? DW'({A[WIDTH-2:0], A[WIDTH-1]})
                                    : DW'({A[0], A[WIDTH-1:1]});
        default:  res_c = '0;
      endcase
    end
  end

  // Next-state and result/counter update.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    par_d       = par_q;
    inv_d       = inv_q;
    cnt_d       = cnt_q;
    mul_start_c = 1'b0;
    case (state_q)
      S_MUL: begin
        if (mul_done && !mul_busy) begin
          state_d = S_DONE;
          out_d   = mul_product;
          par_d   = ^mul_product;
          inv_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept_c) begin
      if (req_mul_c) begin
        state_d     = S_MUL;
        mul_start_c = 1'b1;
      end else begin
        state_d = S_DONE;
        out_d   = res_c;
        par_d   = ^res_c;
        inv_d   = req_inv_c;
      end
      if (req_inv_c && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      par_q   <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      par_q   <= par_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start_c),
    .a      (A),
    .b      (B),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  assign Out         = out_q;
  assign Odd_parity  = par_q;
  assign Invalid     = inv_q;
  assign invalid_cnt = cnt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases, then random traffic against a transaction model.
module tb_alu_seq;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  A = '0, B = '0;
  logic          cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
  logic          red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
  logic [2:0]    opcode = 3'b000;
  logic          out_ready = 1'b1;

  logic          in_ready, out_valid, Odd_parity, Invalid;
  logic [DW-1:0] Out;
  logic [7:0]    invalid_cnt;
  logic          in_ready2, out_valid2, Odd_parity2, Invalid2;
  logic [DW-1:0] Out2;
  logic [1:0]    invalid_cnt2;

  int n_pass  = 0;
  int n_total = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .FULL_ADDER(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .Odd_parity(Odd_parity), .Invalid(Invalid), .invalid_cnt(invalid_cnt)
  );

  // Narrow counter copy sees identical traffic, so only its counter saturates differently.
  alu_seq #(.WIDTH(W), .FULL_ADDER(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .opcode(opcode), .out_valid(out_valid2), .out_ready(out_ready), .Out(Out2),
    .Odd_parity(Odd_parity2), .Invalid(Invalid2), .invalid_cnt(invalid_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result from the operation definitions, using plain integer arithmetic.
  function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input int a, input int b,
                                               input int ci, input int si, input bit dir,
                                               input bit ra, input bit rb, input bit ba,
                                               input bit bb, output bit inv);
    int mask;
    int r;
    mask = (1 << W) - 1;
    inv  = (op >= 6) || ((ra || rb) && op >= 2 && op <= 5);
    if (inv)     r = 0;
    else if (ba) r = a;
    else if (bb) r = b;
    else begin
      case (op)
        3'd0: r = ra ? int'(a == mask) : rb ? int'(b == mask) : (a & b);
        3'd1: r = ra ? ($countones(a) % 2) : rb ? ($countones(b) % 2) : (a ^ b);
        3'd2: r = a + b + ci;
        3'd3: r = a * b;
        3'd4: r = dir ? (((a << 1) | si) & mask) : ((a >> 1) | (si << (W - 1)));
        3'd5: r = dir ? (((a << 1) | (a >> (W - 1))) & mask) : ((a >> 1) | ((a & 1) << (W - 1)));
        default: r = 0;
      endcase
    end
    return DW'(r);
  endfunction

  // Transaction model: one result in flight, m_cd cycles until it becomes visible.
  bit            m_pend = 1'b0;
  int            m_cd   = 0;
  logic [DW-1:0] m_out  = '0;
  bit            m_inv  = 1'b0;
  int            m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    bit v, rdy, inv;
    logic [DW-1:0] r;
    if (!rst_n) begin
      m_pend = 1'b0; m_cd = 0; m_out = '0; m_inv = 1'b0; m_cnt = 0;
    end else begin
      v   = m_pend && (m_cd == 0);
      rdy = !m_pend || (v && out_ready);
      if (v && out_ready) m_pend = 1'b0;
      else if (m_pend && m_cd > 0) m_cd--;
      if (in_valid && rdy) begin
        r = ref_result(opcode, int'(A), int'(B), int'(cin), int'(serial_in), direction,
                       red_op_A, red_op_B, bypass_A, bypass_B, inv);
        m_out  = r;
        m_inv  = inv;
        m_pend = 1'b1;
        m_cd   = (opcode == 3'd3 && !inv && !bypass_A && !bypass_B) ? W : 0;
        if (inv && m_cnt < 255) m_cnt++;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    if (running) begin
      exp_v   = m_pend && (m_cd == 0);
      exp_rdy = !m_pend || (exp_v && out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("invalid_cnt", 32'(invalid_cnt), 32'(m_cnt));
      check("in_ready_w2", 32'(in_ready2), 32'(exp_rdy));
      check("out_valid_w2", 32'(out_valid2), 32'(exp_v));
      check("invalid_cnt_w2", 32'(invalid_cnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
      if (exp_v) begin
        check("Out", 32'(Out), 32'(m_out));
        check("Odd_parity", 32'(Odd_parity), 32'(^m_out));
        check("Invalid", 32'(Invalid), 32'(m_inv));
        check("Out_w2", 32'(Out2), 32'(m_out));
        check("Odd_parity_w2", 32'(Odd_parity2), 32'(^m_out));
        check("Invalid_w2", 32'(Invalid2), 32'(m_inv));
      end
      if (!rst_n) begin
        check("Out_in_reset", 32'(Out), 32'(0));
        check("Invalid_in_reset", 32'(Invalid), 32'(0));
      end
    end
  end

  // Present a request at a negedge and hold it until the posedge that accepts it.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic si, input logic dir,
                      input logic ra, input logic rb, input logic ba, input logic bb);
    int n;
    @(negedge clk);
    opcode = op; A = a; B = b; cin = ci; serial_in = si; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("send_accept_bound", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = ~A; B = ~B; cin = ~cin; opcode = 3'b111;
  endtask

  // Count cycles from the accept edge until out_valid, noting whether in_ready stayed low.
  task automatic wait_valid(output int lat, output bit ready_low);
    bit got;
    got = 1'b0; lat = 0; ready_low = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
      else if (in_ready) ready_low = 1'b0;
    end
    check("wait_valid_bound", 32'(got), 32'(1));
  endtask

  task automatic rand_fields();
    opcode    = 3'($urandom_range(0, 7));
    A         = W'($urandom);
    B         = W'($urandom);
    cin       = 1'($urandom);
    serial_in = 1'($urandom);
    direction = 1'($urandom);
    red_op_A  = ($urandom % 8) == 0;
    red_op_B  = ($urandom % 8) == 0;
    bypass_A  = ($urandom % 10) == 0;
    bypass_B  = ($urandom % 10) == 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  rl;
    bit  acc;
    logic [DW-1:0] held;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_Out", 32'(Out), 32'(0));
    check("rst_Odd_parity", 32'(Odd_parity), 32'(0));
    check("rst_invalid_cnt", 32'(invalid_cnt), 32'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // ADD with carry-in: 0xF + 0x1 + 1.
    send(3'b010, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("add_latency", 32'(lat), 32'(1));
    check("add_Out", 32'(Out), 32'h11);
    check("add_parity", 32'(Odd_parity), 32'(0));
    check("add_Invalid", 32'(Invalid), 32'(0));

    // MUL 0xD * 0xB.
    send(3'b011, 4'hD, 4'hB, 0, 0, 0, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("mul_latency", 32'(lat), 32'(W + 1));
    check("mul_in_ready_low", 32'(rl), 32'(1));
    check("mul_Out", 32'(Out), 32'h8F);
    check("mul_parity", 32'(Odd_parity), 32'(1));

    // Invalid requests.
    send(3'b110, 4'h3, 4'h4, 0, 0, 0, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("inv_op_Out", 32'(Out), 32'(0));
    check("inv_op_Invalid", 32'(Invalid), 32'(1));
    check("inv_op_cnt", 32'(invalid_cnt), 32'(1));
    send(3'b010, 4'h3, 4'h4, 0, 0, 0, 1, 0, 0, 0);
    wait_valid(lat, rl);
    check("inv_red_Invalid", 32'(Invalid), 32'(1));
    check("inv_red_parity", 32'(Odd_parity), 32'(0));
    check("inv_red_cnt", 32'(invalid_cnt), 32'(2));

    // Rotate left and shift right of 4'b1001.
    send(3'b101, 4'b1001, 4'h0, 0, 0, 1, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("rot_left_Out", 32'(Out), 32'h03);
    send(3'b100, 4'b1001, 4'h0, 0, 1, 0, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("shift_right_Out", 32'(Out), 32'h0C);

    // Backpressure: result held for 3 cycles, then same-cycle release and accept.
    @(negedge clk);
    out_ready = 1'b0;
    send(3'b000, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0, 0);
    wait_valid(lat, rl);
    check("bp_Out", 32'(Out), 32'h08);
    held = Out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_Out", 32'(Out), 32'(held));
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_hold_in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    opcode = 3'b001; A = 4'h5; B = 4'h3; red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
    in_valid = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 4'hF; B = 4'hF;
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'(1));
    check("b2b_Out", 32'(Out), 32'h06);

    // Reset two cycles into a multiply.
    send(3'b011, 4'h7, 4'h7, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_Out", 32'(Out), 32'(0));
    check("mid_rst_cnt", 32'(invalid_cnt), 32'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'(0));
    end

    // Random traffic with random backpressure; requests held until accepted.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom % 4) != 0;
      if (acc || !in_valid) begin
        in_valid = ($urandom % 3) != 0;
        rand_fields();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("final_cnt_saturated", 32'(invalid_cnt), 32'((m_cnt > 255) ? 255 : m_cnt));

    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked successor to the combinational ALU, with parametrised operand width.
- Accepts one operation per valid/ready transaction and returns a registered result with odd parity and an Invalid flag.
- Multiply is computed by an iterative shift-add engine taking WIDTH cycles; all other ops complete in 1 cycle.
- Keeps a saturating count of invalid requests; sits between the instruction issue stage and the result writeback.

Parameters:
- WIDTH, 4: operand width in bits; must be >= 2.
- FULL_ADDER, 1: 1 means ADD uses cin; 0 means cin is ignored.
- CNT_W, 8: width of the saturating invalid-request counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry-in for ADD.
- serial_in  in  1  fill bit for SHIFT.
- direction  in  1  1 = left, 0 = right, for SHIFT and ROTATE.
- red_op_A  in  1  reduction of A for AND/XOR.
- red_op_B  in  1  reduction of B for AND/XOR.
- bypass_A  in  1  Out = A.
- bypass_B  in  1  Out = B.
- opcode  in  3  000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT, 101 ROTATE, 110/111 invalid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- Out  out  2*WIDTH  result, zero-extended.
- Odd_parity  out  1  XOR of all bits of Out.
- Invalid  out  1  request was invalid.
- invalid_cnt  out  CNT_W  saturating count of accepted invalid requests.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, Out=0, Odd_parity=0, Invalid=0, invalid_cnt=0; in_ready=1 from the first clk after release.
- FSM states:
  - IDLE: on accept (in_valid & in_ready), a MUL request goes to MUL; any other request goes to DONE.
  - MUL: runs exactly WIDTH iterations, then goes to DONE.
  - DONE: on out_ready goes to IDLE, or directly to MUL/DONE if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is 0 throughout MUL.
- out_valid = (state==DONE). Out, Odd_parity and Invalid are held stable while out_valid & ~out_ready.
- Latency from the accept edge to out_valid: 1 cycle for non-MUL ops; WIDTH+1 cycles for MUL.
- All operand and control inputs are captured at accept; later input changes have no effect.
- Result priority (highest first):
  1. Invalid: opcode 110/111, or (red_op_A | red_op_B) with opcode 010–101. Gives Out=0, Invalid=1.
  2. bypass_A: Out = A.
  3. bypass_B: Out = B.
  4. opcode.
- Opcode results:
  - AND/XOR: red_op_A (priority over red_op_B) gives &A or ^A; red_op_B gives &B or ^B; otherwise bitwise A op B.
  - ADD: A+B+(cin & FULL_ADDER), WIDTH+1 bits.
  - MUL: unsigned A*B, 2*WIDTH bits.
  - SHIFT: left = {A[WIDTH-2:0], serial_in}; right = {serial_in, A[WIDTH-1:1]}.
  - ROTATE: rotate A by 1 in the given direction.
  - All results are zero-extended to 2*WIDTH.
- Odd_parity is registered with Out; it is 0 when Invalid=1.
- invalid_cnt increments at accept of an invalid request and saturates at all-ones with no wrap.
- Reset asserted mid-MUL or mid-DONE aborts immediately; the pending result is discarded.

Decomposition:
- Package alu_pkg holds: opcode localparams (OP_AND..OP_ROT), FSM state encoding (S_IDLE, S_MUL, S_DONE), and an is_invalid function.
- One sub-module, alu_seq_mul: iterative shift-add multiplier.
  - Ports: start, a, b; busy, done, product[2*WIDTH-1:0].
  - Same clk/rst_n; done pulses exactly WIDTH cycles after start.

Test Plan:
- ADD, WIDTH=4, FULL_ADDER=1: A=4'hF, B=4'h1, cin=1 -> out_valid 1 cycle after accept, Out=8'h11, Odd_parity=0, Invalid=0.
- MUL: A=4'hD, B=4'hB -> in_ready=0 for 4 cycles, out_valid at accept+5, Out=8'h8F, Odd_parity=1.
- Invalid: opcode=110 -> Out=0, Invalid=1, invalid_cnt 0->1. opcode=010 with red_op_A=1 -> Invalid=1, invalid_cnt=2. With CNT_W=2, five invalid requests -> invalid_cnt=3.
- ROTATE/SHIFT: A=4'b1001, direction=1, ROTATE -> Out=8'h03. SHIFT right with serial_in=1 -> Out=8'h0C.
- Backpressure and back-to-back: hold out_ready=0 for 3 cycles -> Out stable and in_ready=0. Then raise out_ready=1 with in_valid=1 (XOR, A=4'h5, B=4'h3) -> accepted in the same cycle, next Out=8'h06.
- Reset mid-MUL: assert rst_n=0 two cycles into a MUL -> out_valid=0 and Out=0 immediately (asynchronous); in_ready=1 after release; no stale result appears.
